// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller of the dual-clock FIFO: owns the binary/Gray
// write pointers, synchronizes the read Gray pointer in, and derives fill
// level plus full/almost-full from the write side's view.
module fifo_wr_ctrl #(
  parameter int AWIDTH          = 4,
  parameter int ALMOST_FULL_VAL = 2**AWIDTH-2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              full_o,
  output logic              almost_full_o
);

  localparam int PW = AWIDTH + 1;
  localparam logic [AWIDTH:0] DEPTH  = PW'(2**AWIDTH);
  localparam logic [AWIDTH:0] AF_LVL = PW'(ALMOST_FULL_VAL);

  logic [AWIDTH:0] wr_bin, wr_bin_next;
  logic [AWIDTH:0] sync1, sync2;

  // full-width Gray->binary, MSB included, so pointer wrap is handled
  function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
    logic [AWIDTH:0] b;
    b[AWIDTH] = g[AWIDTH];
    for (int i = AWIDTH-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // accept decode and next pointer; the only input-to-output comb path
  always_comb begin
    wr_en_o     = wrreq_i & ~full_o & ~srst_i;
    wr_bin_next = wr_bin + {{AWIDTH{1'b0}}, wr_en_o};
  end

  assign wr_addr_o = wr_bin[AWIDTH-1:0];

  // pointers, two-flop synchronizer and registered fill level
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_bin         <= '0;
      wr_pntr_gray_o <= '0;
      sync1          <= '0;
      sync2          <= '0;
      usedw_o        <= '0;
    end else begin
      wr_bin         <= wr_bin_next;
      wr_pntr_gray_o <= wr_bin_next ^ (wr_bin_next >> 1);
      sync1          <= rd_pntr_gray_i;
      sync2          <= sync1;
      // sync1 here is what sync2 holds after this edge, so usedw_o tracks sync2
      usedw_o        <= wr_bin_next - gray2bin(sync1);
    end
  end

  // flags are pure decodes of the registered fill level
  always_comb begin
    full_o        = (usedw_o == DEPTH);
    almost_full_o = (usedw_o >= AF_LVL);
  end

  // fill level always equals write pointer minus the second-stage read pointer
  a_usedw_sync2: assert property (@(posedge clk_i)
    usedw_o == wr_bin - gray2bin(sync2));

  // outgoing Gray pointer never moves more than one bit per clock
  a_gray_step: assert property (@(posedge clk_i)
    !srst_i && !$past(srst_i) |-> $countones(wr_pntr_gray_o ^ $past(wr_pntr_gray_o)) <= 1);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (AWIDTH=4, almost-full at 14).
module tb_fifo_wr_ctrl;
  logic       clk = 1'b0;
  logic       srst;
  logic       wrreq;
  logic [4:0] rd_gray;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic [4:0] usedw;
  logic       full;
  logic       afull;

  int errors = 0;
  int checks = 0;

  fifo_wr_ctrl #(.AWIDTH(4), .ALMOST_FULL_VAL(14)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .wrreq_i        (wrreq),
    .rd_pntr_gray_i (rd_gray),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_pntr_gray_o (wr_gray),
    .usedw_o        (usedw),
    .full_o         (full),
    .almost_full_o  (afull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] g(input int x);
    logic [4:0] b;
    b = 5'(x);
    return b ^ (b >> 1);
  endfunction

  // outputs sampled 2 time units after the active edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [4:0] prev;
  int wa [4] = '{14, 15, 0, 1};
  int cu [5] = '{9, 10, 10, 10, 10};

  initial begin
    srst = 1'b1; wrreq = 1'b1; rd_gray = '0;
    // reset with a pending request
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_gray", wr_gray, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);

    // fill 16 entries with read pointer parked at 0
    srst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fill_wr_en", wr_en, 1);
      chk("fill_addr", wr_addr, i);
      tick();
      chk("fill_usedw", usedw, i + 1);
      chk("fill_afull", afull, (i + 1 >= 14) ? 1 : 0);
      chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
    end
    chk("fill_gray_end", wr_gray, 5'b11000);

    // overflow: requests dropped, pointer held at 16
    for (int i = 0; i < 3; i++) begin
      chk("ovf_wr_en", wr_en, 0);
      tick();
      chk("ovf_addr", wr_addr, 0);
      chk("ovf_usedw", usedw, 16);
      chk("ovf_full", full, 1);
      chk("ovf_gray", wr_gray, 5'b11000);
    end

    // drain visibility: read pointer 4 shows up two edges later
    wrreq = 1'b0; rd_gray = 5'b00110;
    tick();
    chk("drain_k_usedw", usedw, 16);
    chk("drain_k_full", full, 1);
    tick();
    chk("drain_k1_usedw", usedw, 12);
    chk("drain_k1_full", full, 0);
    chk("drain_k1_afull", afull, 0);

    // empty out (read=16), then write 14 to reach pointer 30
    rd_gray = g(16);
    tick(); tick();
    chk("empty_usedw", usedw, 0);
    wrreq = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("to30_usedw", usedw, 14);
    chk("to30_gray", wr_gray, 5'b10001);
    chk("to30_afull", afull, 1);
    wrreq = 1'b0; rd_gray = g(30);
    tick(); tick();
    chk("at30_usedw", usedw, 0);
    chk("at30_afull", afull, 0);

    // wrap-around: 30 -> 31 -> 0 -> 1 -> 2
    wrreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prev = wr_gray;
      #1;
      chk("wrap_addr", wr_addr, wa[i]);
      tick();
      chk("wrap_gray", wr_gray, g(31 + i));
      chk("wrap_flip", $countones(wr_gray ^ prev), 1);
      chk("wrap_usedw", usedw, i + 1);
    end
    // four more writes: pointer 6, usedw 8
    for (int i = 0; i < 4; i++) tick();
    chk("pre_conc_usedw", usedw, 8);

    // concurrent: write every cycle; read starts advancing one cycle later
    // e1: 7-30=9, e2: 8-30=10, e3: 9-31=10, e4: 10-0=10, e5: 11-1=10
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("conc_usedw", usedw, cu[i]);
      chk("conc_afull", afull, 0);
      rd_gray = g(31 + i);
    end

    // mid-stream reset
    srst = 1'b1;
    #1;
    chk("mrst_wr_en_comb", wr_en, 0);
    tick();
    chk("mrst_gray", wr_gray, 0);
    chk("mrst_addr", wr_addr, 0);
    chk("mrst_usedw", usedw, 0);
    chk("mrst_full", full, 0);
    chk("mrst_afull", afull, 0);
    srst = 1'b0; wrreq = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
